logic_axi4_stream_packet_generator: RTL and testbench
=====================================================

// Module: logic_axi4_stream_packet_generator
// PURPOSE
// - AXI4-Stream transmitter: turns one command (length, seed, sideband) into one packet on tx_*.
// - Source side of the stream buffer/transfer counter path; feeds sinks, buffers and benches.
// - Payload is a deterministic byte-incrementing pattern, so the receiver can check data.
// PARAMETERS
// - TDATA_BYTES   `LOGIC_AXI4_STREAM_TDATA_BYTES  bytes per beat (>=1)
// - TDEST_WIDTH   `LOGIC_AXI4_STREAM_TDEST_WIDTH  tdest width (>=1)
// - TUSER_WIDTH   `LOGIC_AXI4_STREAM_TUSER_WIDTH  tuser width (>=1)
// - TID_WIDTH     `LOGIC_AXI4_STREAM_TID_WIDTH    tid width (>=1)
// - LENGTH_WIDTH  16                              cmd_length width; packet = cmd_length+1 beats
// PORTS
// - aclk            in   1                 clock; all logic on rising edge
// - areset_n        in   1                 asynchronous active-low reset
// - cmd_valid       in   1                 command valid
// - cmd_ready       out  1                 command accepted when cmd_valid && cmd_ready
// - cmd_length      in   LENGTH_WIDTH      beats minus one
// - cmd_seed        in   8                 value of byte 0 of beat 0
// - cmd_tdest       in   TDEST_WIDTH       tdest for whole packet
// - cmd_tuser       in   TUSER_WIDTH       tuser for whole packet
// - cmd_tid         in   TID_WIDTH         tid for whole packet
// - tx_tlast        out  1                 last beat of packet
// - tx_tvalid       out  1                 beat valid
// - tx_tdata        out  TDATA_BYTES*8     pattern data, [TDATA_BYTES-1:0][7:0]
// - tx_tstrb        out  TDATA_BYTES       all ones while tx_tvalid
// - tx_tkeep        out  TDATA_BYTES       all ones while tx_tvalid
// - tx_tdest/tuser/tid  out  per param      latched from command
// - tx_tready       in   1                 downstream ready
// - packet_count    out  32                packets completed (feature-gated)
// - beat_count      out  32                beats transferred (feature-gated)
// BEHAVIOUR
// - Reset (async assert, sync release): state IDLE; tx_tvalid=0, tx_tlast=0, cmd_ready=0 only
//   during reset, all tx payload regs 0, counters 0. Reset mid-packet aborts it; tx_tvalid
//   drops immediately, no resume after release.
// - States: IDLE, SEND. cmd_ready = (IDLE) || (SEND && tx_tvalid && tx_tready && tx_tlast).
// - IDLE -> SEND on command accept; registers latched; tx_tvalid=1 on the next cycle (1-cycle latency).
// - Beat i (0-based), byte k: tx_tdata[k] = (cmd_seed + i*TDATA_BYTES + k) mod 256.
// - tx_tlast=1 exactly on beat i == cmd_length; cmd_length=0 -> single beat, tlast=1.
// - AXI rule: once tx_tvalid=1, all tx_* stable until tx_tready=1; tvalid never drops mid-packet.
// - Beat advances only on tx_tvalid && tx_tready; beat index width LENGTH_WIDTH, never wraps.
// - Last-beat handshake with new command in same cycle: back-to-back; new packet beat 0 next
//   cycle, no bubble. Without command: return IDLE, tx_tvalid=0, tx_tlast=0.
// - tx_tready low for any number of cycles: pure stall, no data change.
// - cmd_* ignored while cmd_ready=0; command fields sampled only at accept.
// CONFIGURATION
// - LOGIC_AXI4_STREAM_PACKET_GENERATOR_COUNTERS_EN defined: beat_count +1 per tx handshake,
//   packet_count +1 per handshake with tx_tlast=1; both 32-bit, wrap 0xFFFFFFFF -> 0.
// - Not defined: packet_count and beat_count tied to 0, no counter flops.
// TESTING (TDATA_BYTES=4)
// - Single beat: length=0, seed=0x10, tready=1 -> one beat, tdata=0x13121110, tlast=1, tkeep=0xF.
// - 3-beat packet: length=2, seed=0xFE -> tdata 0x0100FFFE, 0x05040302, 0x09080706; tlast on 3rd.
// - Backpressure: tready toggles 1010... -> tdata/tlast/tdest stable across stalls, 4 beats exact.
// - Back-to-back: two queued cmds (length=1, 0) -> 3 consecutive valid beats, no tvalid gap.
// - Reset mid-packet: areset_n low at beat 2 of length=7 -> tvalid=0 same cycle; after release
//   cmd_ready=1, no stale beats emitted.
// - Counters (EN): 5 packets of length=3 -> packet_count=5, beat_count=20; preload 0xFFFFFFFF -> wraps to 0.

Source files
------------

// File: rtl/logic_axi4_stream_packet_generator.sv
// AXI4-Stream packet generator: one command becomes one packet with a byte-incrementing payload.
// Optional packet/beat counters are enabled by defining LOGIC_AXI4_STREAM_PACKET_GENERATOR_COUNTERS_EN.
`ifndef LOGIC_AXI4_STREAM_TDATA_BYTES
`define LOGIC_AXI4_STREAM_TDATA_BYTES 4
`endif
`ifndef LOGIC_AXI4_STREAM_TDEST_WIDTH
`define LOGIC_AXI4_STREAM_TDEST_WIDTH 4
`endif
`ifndef LOGIC_AXI4_STREAM_TUSER_WIDTH
`define LOGIC_AXI4_STREAM_TUSER_WIDTH 4
`endif
`ifndef LOGIC_AXI4_STREAM_TID_WIDTH
`define LOGIC_AXI4_STREAM_TID_WIDTH 4
`endif

module logic_axi4_stream_packet_generator #(
    parameter int unsigned TDATA_BYTES  = `LOGIC_AXI4_STREAM_TDATA_BYTES,
    parameter int unsigned TDEST_WIDTH  = `LOGIC_AXI4_STREAM_TDEST_WIDTH,
    parameter int unsigned TUSER_WIDTH  = `LOGIC_AXI4_STREAM_TUSER_WIDTH,
    parameter int unsigned TID_WIDTH    = `LOGIC_AXI4_STREAM_TID_WIDTH,
    parameter int unsigned LENGTH_WIDTH = 16
) (
    input  logic                      aclk,
    input  logic                      areset_n,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [LENGTH_WIDTH-1:0]   cmd_length,
    input  logic [7:0]                cmd_seed,
    input  logic [TDEST_WIDTH-1:0]    cmd_tdest,
    input  logic [TUSER_WIDTH-1:0]    cmd_tuser,
    input  logic [TID_WIDTH-1:0]      cmd_tid,
    output logic                      tx_tlast,
    output logic                      tx_tvalid,
    output logic [TDATA_BYTES*8-1:0]  tx_tdata,
    output logic [TDATA_BYTES-1:0]    tx_tstrb,
    output logic [TDATA_BYTES-1:0]    tx_tkeep,
    output logic [TDEST_WIDTH-1:0]    tx_tdest,
    output logic [TUSER_WIDTH-1:0]    tx_tuser,
    output logic [TID_WIDTH-1:0]      tx_tid,
    input  logic                      tx_tready,
    output logic [31:0]               packet_count,
    output logic [31:0]               beat_count
);

    localparam int unsigned DATA_W = TDATA_BYTES * 8;

    typedef enum logic {IDLE, SEND} state_t;

    state_t                  state_q, state_d;
    logic                    active_q;
    logic [LENGTH_WIDTH-1:0] beat_q, beat_d;
    logic [LENGTH_WIDTH-1:0] len_q, len_d;
    logic [DATA_W-1:0]       data_q, data_d;
    logic                    last_q, last_d;
    logic                    valid_q, valid_d;
    logic [TDEST_WIDTH-1:0]  dest_q, dest_d;
    logic [TUSER_WIDTH-1:0]  user_q, user_d;
    logic [TID_WIDTH-1:0]    id_q, id_d;
    logic                    hs;
    logic                    accept;
    logic                    load;

    // active_q keeps cmd_ready low while reset is asserted even though the FSM sits in IDLE
    assign hs        = valid_q && tx_tready;
    assign cmd_ready = active_q && ((state_q == IDLE) || (hs && last_q));
    assign accept    = cmd_valid && cmd_ready;

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state_q  <= IDLE;
            active_q <= 1'b0;
            beat_q   <= '0;
            len_q    <= '0;
            data_q   <= '0;
            last_q   <= 1'b0;
            valid_q  <= 1'b0;
            dest_q   <= '0;
            user_q   <= '0;
            id_q     <= '0;
        end else begin
            state_q  <= state_d;
            active_q <= 1'b1;
            beat_q   <= beat_d;
            len_q    <= len_d;
            data_q   <= data_d;
            last_q   <= last_d;
            valid_q  <= valid_d;
            dest_q   <= dest_d;
            user_q   <= user_d;
            id_q     <= id_d;
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        len_d   = len_q;
        data_d  = data_q;
        last_d  = last_q;
        valid_d = valid_q;
        dest_d  = dest_q;
        user_d  = user_q;
        id_d    = id_q;
        load    = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) load = 1'b1;
            end
            SEND: begin
                if (accept) begin
                    load = 1'b1;
                end else if (hs && last_q) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                end else if (hs) begin
                    beat_d = beat_q + LENGTH_WIDTH'(1);
                    last_d = (beat_d == len_q);
                    for (int unsigned k = 0; k < TDATA_BYTES; k++) begin
                        data_d[k*8 +: 8] = data_q[k*8 +: 8] + 8'(TDATA_BYTES);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Beat 0 of a new packet, either from IDLE or back-to-back after a last beat
        if (load) begin
            state_d = SEND;
            valid_d = 1'b1;
            beat_d  = '0;
            len_d   = cmd_length;
            last_d  = (cmd_length == '0);
            dest_d  = cmd_tdest;
            user_d  = cmd_tuser;
            id_d    = cmd_tid;
            for (int unsigned k = 0; k < TDATA_BYTES; k++) begin
                data_d[k*8 +: 8] = cmd_seed + 8'(k);
            end
        end
    end

    assign tx_tvalid = valid_q;
    assign tx_tlast  = last_q;
    assign tx_tdata  = data_q;
    assign tx_tstrb  = {TDATA_BYTES{valid_q}};
    assign tx_tkeep  = {TDATA_BYTES{valid_q}};
    assign tx_tdest  = dest_q;
    assign tx_tuser  = user_q;
    assign tx_tid    = id_q;

`ifdef LOGIC_AXI4_STREAM_PACKET_GENERATOR_COUNTERS_EN
    logic [31:0] packet_cnt_q;
    logic [31:0] beat_cnt_q;

    // Free-running statistics, wrapping naturally at 32 bits
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            packet_cnt_q <= '0;
            beat_cnt_q   <= '0;
        end else if (hs) begin
            beat_cnt_q <= beat_cnt_q + 32'd1;
            if (last_q) packet_cnt_q <= packet_cnt_q + 32'd1;
        end
    end

    assign packet_count = packet_cnt_q;
    assign beat_count   = beat_cnt_q;
`else
    assign packet_count = 32'd0;
    assign beat_count   = 32'd0;
`endif

endmodule

// File: tb/tb_logic_axi4_stream_packet_generator.sv
// Scoreboard bench for logic_axi4_stream_packet_generator with 4-byte beats and 4-bit sidebands.
module tb_logic_axi4_stream_packet_generator;

    logic        aclk = 1'b0;
    logic        areset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_length;
    logic [7:0]  cmd_seed;
    logic [3:0]  cmd_tdest;
    logic [3:0]  cmd_tuser;
    logic [3:0]  cmd_tid;
    logic        tx_tlast;
    logic        tx_tvalid;
    logic [31:0] tx_tdata;
    logic [3:0]  tx_tstrb;
    logic [3:0]  tx_tkeep;
    logic [3:0]  tx_tdest;
    logic [3:0]  tx_tuser;
    logic [3:0]  tx_tid;
    logic        tx_tready;
    logic [31:0] packet_count;
    logic [31:0] beat_count;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic [3:0]  dest;
        logic [3:0]  user;
        logic [3:0]  id;
    } beat_t;

    beat_t       exp_q[$];
    int unsigned hs_cyc[$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic        held = 1'b0;
    logic [31:0] held_data;
    logic        held_last;
    logic [3:0]  held_dest;

    logic_axi4_stream_packet_generator #(
        .TDATA_BYTES (4),
        .TDEST_WIDTH (4),
        .TUSER_WIDTH (4),
        .TID_WIDTH   (4),
        .LENGTH_WIDTH(16)
    ) dut (
        .aclk        (aclk),
        .areset_n    (areset_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_length  (cmd_length),
        .cmd_seed    (cmd_seed),
        .cmd_tdest   (cmd_tdest),
        .cmd_tuser   (cmd_tuser),
        .cmd_tid     (cmd_tid),
        .tx_tlast    (tx_tlast),
        .tx_tvalid   (tx_tvalid),
        .tx_tdata    (tx_tdata),
        .tx_tstrb    (tx_tstrb),
        .tx_tkeep    (tx_tkeep),
        .tx_tdest    (tx_tdest),
        .tx_tuser    (tx_tuser),
        .tx_tid      (tx_tid),
        .tx_tready   (tx_tready),
        .packet_count(packet_count),
        .beat_count  (beat_count)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] d, input logic l, input logic [3:0] de,
                        input logic [3:0] us, input logic [3:0] id);
        beat_t b;
        b.data = d;
        b.last = l;
        b.dest = de;
        b.user = us;
        b.id   = id;
        exp_q.push_back(b);
    endtask

    // Reference payload for packets whose expected beats are not listed by hand
    task automatic push_pkt(input int unsigned len, input logic [7:0] seed, input logic [3:0] de,
                            input logic [3:0] us, input logic [3:0] id);
        for (int unsigned i = 0; i <= len; i++) begin
            logic [31:0] d;
            for (int unsigned k = 0; k < 4; k++) d[k*8 +: 8] = seed + 8'(i * 4 + k);
            push(d, i == len, de, us, id);
        end
    endtask

    // Called just after a rising edge; returns just after the edge that accepted the command
    task automatic send(input logic [15:0] len, input logic [7:0] seed, input logic [3:0] de,
                        input logic [3:0] us, input logic [3:0] id);
        cmd_length = len;
        cmd_seed   = seed;
        cmd_tdest  = de;
        cmd_tuser  = us;
        cmd_tid    = id;
        cmd_valid  = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge aclk);
            if (cmd_ready) begin
                @(posedge aclk);
                #1;
                cmd_valid = 1'b0;
                return;
            end
            @(posedge aclk);
            #1;
        end
        checks++;
        errors++;
        $display("FAIL cmd_accept_timeout actual=no_accept required=accept");
        cmd_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int n = 0; n < 200 && exp_q.size() != 0; n++) @(posedge aclk);
        #1;
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: pops expectations on each handshake and checks stability while stalled
    always @(negedge aclk) begin
        if (!areset_n) begin
            held = 1'b0;
        end else begin
            cyc++;
            if (held) begin
                check("stall_tvalid", 64'(tx_tvalid), 64'd1);
                check("stall_tdata", 64'(tx_tdata), 64'(held_data));
                check("stall_tlast", 64'(tx_tlast), 64'(held_last));
                check("stall_tdest", 64'(tx_tdest), 64'(held_dest));
            end
            if (tx_tvalid && tx_tready) begin
                hs_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat actual=%08h required=no_beat", tx_tdata);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check("tdata", 64'(tx_tdata), 64'(e.data));
                    check("tlast", 64'(tx_tlast), 64'(e.last));
                    check("tdest", 64'(tx_tdest), 64'(e.dest));
                    check("tuser", 64'(tx_tuser), 64'(e.user));
                    check("tid", 64'(tx_tid), 64'(e.id));
                    check("tkeep", 64'(tx_tkeep), 64'hF);
                    check("tstrb", 64'(tx_tstrb), 64'hF);
                end
            end
            held      = tx_tvalid && !tx_tready;
            held_data = tx_tdata;
            held_last = tx_tlast;
            held_dest = tx_tdest;
        end
    end

    initial begin
        int unsigned base;
        areset_n   = 1'b0;
        cmd_valid  = 1'b0;
        cmd_length = '0;
        cmd_seed   = '0;
        cmd_tdest  = '0;
        cmd_tuser  = '0;
        cmd_tid    = '0;
        tx_tready  = 1'b0;

        repeat (3) @(posedge aclk);
        #1;
        check("rst_tvalid", 64'(tx_tvalid), 64'd0);
        check("rst_tlast", 64'(tx_tlast), 64'd0);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        check("rst_tdata", 64'(tx_tdata), 64'd0);
        check("rst_packet_count", 64'(packet_count), 64'd0);
        check("rst_beat_count", 64'(beat_count), 64'd0);
        @(negedge aclk);
        areset_n = 1'b1;
        @(posedge aclk);
        #1;
        check("ready_after_reset", 64'(cmd_ready), 64'd1);

        // Single beat, seed 0x10
        push(32'h13121110, 1'b1, 4'h1, 4'h2, 4'h3);
        send(16'd0, 8'h10, 4'h1, 4'h2, 4'h3);
        check("latency_tvalid", 64'(tx_tvalid), 64'd1);
        tx_tready = 1'b1;
        drain("drain_single");

        // Three beats, seed wraps through 0xFF
        push(32'h0100FFFE, 1'b0, 4'hA, 4'hB, 4'hC);
        push(32'h05040302, 1'b0, 4'hA, 4'hB, 4'hC);
        push(32'h09080706, 1'b1, 4'hA, 4'hB, 4'hC);
        send(16'd2, 8'hFE, 4'hA, 4'hB, 4'hC);
        drain("drain_three");
        check("idle_tvalid", 64'(tx_tvalid), 64'd0);

        // Backpressure: tready toggles every cycle
        tx_tready = 1'b0;
        push(32'h23222120, 1'b0, 4'h3, 4'h5, 4'h7);
        push(32'h27262524, 1'b0, 4'h3, 4'h5, 4'h7);
        push(32'h2B2A2928, 1'b0, 4'h3, 4'h5, 4'h7);
        push(32'h2F2E2D2C, 1'b1, 4'h3, 4'h5, 4'h7);
        send(16'd3, 8'h20, 4'h3, 4'h5, 4'h7);
        for (int i = 0; i < 16; i++) begin
            @(posedge aclk);
            #1;
            tx_tready = ~tx_tready;
        end
        tx_tready = 1'b1;
        drain("drain_backpressure");

        // Back-to-back commands: three consecutive beats
        base = hs_cyc.size();
        push(32'h43424140, 1'b0, 4'h4, 4'h4, 4'h4);
        push(32'h47464544, 1'b1, 4'h4, 4'h4, 4'h4);
        push(32'h83828180, 1'b1, 4'h8, 4'h9, 4'hA);
        send(16'd1, 8'h40, 4'h4, 4'h4, 4'h4);
        send(16'd0, 8'h80, 4'h8, 4'h9, 4'hA);
        drain("drain_b2b");
        check("b2b_beats", 64'(hs_cyc.size() - base), 64'd3);
        if (hs_cyc.size() >= base + 3)
            check("b2b_span", 64'(hs_cyc[base+2] - hs_cyc[base]), 64'd2);

        // Reset while beat 2 of an 8-beat packet is stalled
        tx_tready = 1'b0;
        push(32'h03020100, 1'b0, 4'h6, 4'h6, 4'h6);
        push(32'h07060504, 1'b0, 4'h6, 4'h6, 4'h6);
        send(16'd7, 8'h00, 4'h6, 4'h6, 4'h6);
        tx_tready = 1'b1;
        repeat (2) @(posedge aclk);
        #1;
        tx_tready = 1'b0;
        check("beat2_presented", 64'(tx_tdata), 64'h0B0A0908);
        #2;
        areset_n = 1'b0;
        #1;
        check("abort_tvalid", 64'(tx_tvalid), 64'd0);
        check("abort_tdata", 64'(tx_tdata), 64'd0);
        check("abort_cmd_ready", 64'(cmd_ready), 64'd0);
        check("abort_pending", 64'(exp_q.size()), 64'd0);
        repeat (2) @(negedge aclk);
        areset_n = 1'b1;
        tx_tready = 1'b1;
        @(posedge aclk);
        #1;
        check("abort_ready_after", 64'(cmd_ready), 64'd1);
        repeat (5) @(posedge aclk);
        #1;
        check("abort_no_stale", 64'(tx_tvalid), 64'd0);

        // Counter run from a clean reset: 5 packets of 4 beats
        @(negedge aclk);
        areset_n = 1'b0;
        repeat (2) @(negedge aclk);
        areset_n = 1'b1;
        @(posedge aclk);
        #1;
        for (int p = 0; p < 5; p++) push_pkt(3, 8'(p * 17), 4'(p), 4'hE, 4'hD);
        for (int p = 0; p < 5; p++) send(16'd3, 8'(p * 17), 4'(p), 4'hE, 4'hD);
        drain("drain_counters");
        @(posedge aclk);
        #1;
`ifdef LOGIC_AXI4_STREAM_PACKET_GENERATOR_COUNTERS_EN
        check("packet_count", 64'(packet_count), 64'd5);
        check("beat_count", 64'(beat_count), 64'd20);
`else
        check("packet_count", 64'(packet_count), 64'd0);
        check("beat_count", 64'(beat_count), 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
